dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl_pkg.sv | 29 ++
 rtl/dmem_sram.sv | 40 ++++
 rtl/dmem_ctrl.sv | 140 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared constants, FSM state encoding and error codes for the data-memory controller.
// Optional wait-state support is compiled in with `define DMEM_CTRL_WAIT_EN.
package dmem_ctrl_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam logic [DATA_WIDTH-1:0] ZERO = '0;
    localparam logic WRITE_ENABLE = 1'b1;

    localparam logic DMEM_ERR_NONE  = 1'b0;
    localparam logic DMEM_ERR_RANGE = 1'b1;

    // Encodings stay fixed whether or not the wait state exists.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
`ifdef DMEM_CTRL_WAIT_EN
        ST_WAIT = 3'd2,
`endif
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port, word-addressed data array with synchronous write and registered read.
// The read register has a synchronous clear; the array itself is never reset.
module dmem_sram
    import dmem_ctrl_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  rd_en,
    input  logic                  rd_clr,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wdata;
        end
    end

    // rd_clr returns zero for addresses the controller has flagged as out of range.
    always_ff @(posedge clk) begin
        if (srst) begin
            rdata_reg <= ZERO;
        end else if (rd_en) begin
            rdata_reg <= rd_clr ? ZERO : mem[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: read, optional wait states, write (RMW point), one-cycle done.
// Wait states are compiled in only when `define DMEM_CTRL_WAIT_EN is set.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  stall_req_o,
    output logic                  done_o,
    output logic                  err_o
);

    // Byte-lane bits are the mem stage's business; only the word address is kept.
    localparam int WA_W = ADDR_WIDTH - 2;

    state_t          state_reg, state_next;
    logic [WA_W-1:0] addr_reg, addr_next;
    logic            we_reg, we_next;
    logic            out_of_range;
    logic            ram_rd;
    logic            ram_clr;
    logic            ram_wr;
    state_t          after_rd;

    assign out_of_range = (addr_reg >> DEPTH_LOG2) != '0;
    assign after_rd     = we_reg ? ST_WR : ST_DONE;

`ifdef DMEM_CTRL_WAIT_EN
    localparam int CNT_W = cnt_width(WAIT_CYCLES);

    logic [CNT_W-1:0] wait_cnt_reg;
    logic             wait_done;

    assign wait_done = (wait_cnt_reg == '0);

    // Loaded with WAIT_CYCLES-1 so the WAIT state lasts exactly WAIT_CYCLES cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == ST_RD) begin
            wait_cnt_reg <= CNT_W'(WAIT_CYCLES - 1);
        end else if (state_reg == ST_WAIT && !wait_done) begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            we_reg    <= we_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        we_next    = we_reg;
        ram_rd     = 1'b0;
        ram_clr    = 1'b0;
        ram_wr     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_i) begin
                    state_next = ST_RD;
                    addr_next  = addr_i[ADDR_WIDTH-1:2];
                    we_next    = we_i;
                end
            end
            ST_RD: begin
                if (!req_i) begin
                    state_next = ST_IDLE;
                end else begin
                    ram_rd  = 1'b1;
                    ram_clr = out_of_range;
`ifdef DMEM_CTRL_WAIT_EN
                    if (WAIT_CYCLES > 0) begin
                        state_next = ST_WAIT;
                    end else begin
                        state_next = after_rd;
                    end
`else
                    state_next = after_rd;
`endif
                end
            end
`ifdef DMEM_CTRL_WAIT_EN
            ST_WAIT: begin
                if (!req_i) begin
                    state_next = ST_IDLE;
                end else if (wait_done) begin
                    state_next = after_rd;
                end
            end
`endif
            ST_WR: begin
                // Completes even if req_i has dropped; out-of-range stores are discarded.
                ram_wr     = out_of_range ? ~WRITE_ENABLE : WRITE_ENABLE;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    dmem_sram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_sram (
        .clk   (clk_i),
        .srst  (rst_i),
        .rd_en (ram_rd),
        .rd_clr(ram_clr),
        .wr_en (ram_wr && !rst_i),
        .addr  (addr_reg[DEPTH_LOG2-1:0]),
        .wdata (wdata_i),
        .rdata (rdata_o)
    );

    assign stall_req_o = req_i && (state_reg != ST_DONE);
    assign done_o      = (state_reg == ST_DONE);
    assign err_o       = done_o ? (out_of_range ? DMEM_ERR_RANGE : DMEM_ERR_NONE) : 1'b0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: driver pushes expected responses, monitor checks on done_o.
// Works with or without DMEM_CTRL_WAIT_EN defined.
module tb_dmem_ctrl;

    localparam int DL2 = 10;
    localparam int WC  = 2;
`ifdef DMEM_CTRL_WAIT_EN
    localparam int W = WC;
`else
    localparam int W = 0;
`endif
    localparam int NWORDS = 16;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        stall_req_o;
    logic        done_o;
    logic        err_o;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          start;
        logic [31:0] addr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [NWORDS];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;

    dmem_ctrl #(
        .DEPTH_LOG2 (DL2),
        .WAIT_CYCLES(WC)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .stall_req_o(stall_req_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done_o must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (err_o && !done_o) begin
                    tests++;
                    fails++;
                    $display("FAIL err_without_done at cycle %0d", cyc);
                end
                if (done_o) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_done at cycle %0d rdata %h", cyc, rdata_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("rdata", rdata_o, e.rdata);
                        check("err", 32'(err_o), 32'(e.err));
                        check("latency", 32'(cyc - e.start), 32'(e.lat));
                        $display("[TB] done addr=%h rdata=%h err=%0b lat=%0d", e.addr, rdata_o, err_o,
                                 cyc - e.start);
                    end
                end
            end
        end
    end

    function automatic logic is_oor(input logic [31:0] a);
        return (a >> (DL2 + 2)) != 0;
    endfunction

    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   n;
        int   widx;
        logic oor;
        oor   = is_oor(addr);
        widx  = int'(addr[31:2]);
        e.rdata = oor ? 32'h0 : model[widx];
        e.err   = oor;
        e.lat   = (we ? 3 : 2) + W;
        e.start = cyc;
        e.addr  = addr;
        exp_q.push_back(e);
        if (we && !oor) model[widx] = wdata;
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        wdata_i = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) check("stall_busy", 32'(stall_req_o), 32'd1);
        end while (!done_o && n < 40);
        if (!done_o) begin
            tests++;
            fails++;
            $display("FAIL done_timeout addr %h got no done expected done", addr);
        end else begin
            check("stall_in_done", 32'(stall_req_o), 32'd0);
        end
        req_i = 1'b0;
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    endtask

    // Drop req_i k cycles into a store; no write and no done must follow.
    task automatic do_abort(input int k, input logic [31:0] addr, input logic [31:0] wdata);
        req_i   = 1'b1;
        we_i    = 1'b1;
        addr_i  = addr;
        wdata_i = wdata;
        repeat (k) @(negedge clk);
        req_i = 1'b0;
        @(negedge clk);
        check("abort_stall", 32'(stall_req_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        repeat (4) @(negedge clk);
        $display("[TB] abort addr=%h after %0d cycles", addr, k);
    endtask

    task automatic do_reset_in_wr(input logic [31:0] addr, input logic [31:0] wdata);
        req_i   = 1'b1;
        we_i    = 1'b1;
        addr_i  = addr;
        wdata_i = wdata;
        repeat (2 + W) @(negedge clk);
        rst_i = 1'b1;
        req_i = 1'b0;
        @(negedge clk);
        check("rst_wr_rdata", rdata_o, 32'h0);
        check("rst_wr_done", 32'(done_o), 32'd0);
        check("rst_wr_err", 32'(err_o), 32'd0);
        check("rst_wr_stall", 32'(stall_req_o), 32'd0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        $display("[TB] reset during write addr=%h", addr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] mask;
        int          w;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        check("reset_rdata", rdata_o, 32'h0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_err", 32'(err_o), 32'd0);
        check("reset_stall", 32'(stall_req_o), 32'd0);

        // Known contents for the words in use; random low address bits must be ignored.
        for (int i = 0; i < NWORDS; i++) begin
            do_access(1'b1, (32'(i) << 2) | 32'($urandom_range(0, 3)), $urandom);
        end

        do_access(1'b1, 32'h10, 32'h1122_3344);
        do_access(1'b0, 32'h10, 32'h0);
        // SB-style merge: mem stage supplies the merged word.
        do_access(1'b1, 32'h10, 32'h1122_33EE);
        do_access(1'b0, 32'h10, 32'h0);
        do_access(1'b1, 32'h20, 32'hAABB_CCDD);
        do_access(1'b0, 32'h20, 32'h0);

        do_access(1'b0, 32'h0000_1000, 32'h0);
        do_access(1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
        do_access(1'b0, 32'h0, 32'h0);

        do_reset_in_wr(32'h30, 32'h5A5A_A5A5);
        do_access(1'b0, 32'h30, 32'h0);

        do_abort(1, 32'h34, 32'hCAFE_F00D);
        if (W > 0) do_abort(2, 32'h34, 32'h0BAD_F00D);
        do_access(1'b0, 32'h34, 32'h0);

        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                a = (32'($urandom_range(1 << DL2, 16383)) << 2) | 32'($urandom_range(0, 3));
                do_access(1'($urandom_range(0, 1)), a, $urandom);
            end else begin
                w = int'($urandom_range(0, NWORDS - 1));
                a = (32'(w) << 2) | 32'($urandom_range(0, 3));
                mask = 32'hFF << (8 * $urandom_range(0, 3));
                d = (model[w] & ~mask) | ($urandom & mask);
                do_access(1'($urandom_range(0, 1)), a, d);
            end
        end

        for (int i = 0; i < NWORDS; i++) begin
            do_access(1'b0, 32'(i) << 2, 32'h0);
        end

        repeat (10) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
